ifetch16: RTL and testbench
===========================

Name: ifetch16

Overview:
- Instruction fetch stage directly upstream of the 8-bit core; drives the core's 16-bit `inst` input.
- Fetches instruction words from instruction memory through a req/ack handshake and keeps a program counter.
- Buffers up to DEPTH prefetched words and presents the oldest one to the core with a valid flag.
- The core pops the word with its IR load enable. A redirect input flushes the buffer and restarts fetch at a new address.

Parameters:
AW, 8, instruction address width (word addresses)
DEPTH, 2, prefetch buffer entries (power of two, >=2)
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
mem_req  out  1  fetch request to instruction memory
mem_addr  out  AW  word address of current request
mem_ack  in  1  memory completes request this cycle
mem_data  in  16  instruction word, valid when mem_ack=1
inst  out  16  oldest buffered instruction, to core inst input
inst_vld  out  1  inst holds a valid word
inst_pc  out  AW  address of the word on inst
irie  in  1  core consumes head word (its IR load enable)
redir  in  1  redirect request (jump/branch taken)
redir_pc  in  AW  redirect target address

Behaviour:
- Reset (rst=0, async): state=IDLE, fetch_pc=RESET_PC, count=0, mem_req=0, mem_addr=RESET_PC, inst=16'h0000, inst_vld=0, inst_pc=0.
- FSM states: IDLE, FETCH, DROP.
  - IDLE: mem_req=0; next state is always FETCH. The first request therefore appears in the 2nd cycle after rst deasserts.
  - FETCH: mem_req = (count < DEPTH); mem_addr = fetch_pc.
  - DROP: mem_req=1; mem_addr = drop_addr, the address of the unacknowledged request.
- Memory handshake:
  - Once asserted, mem_req stays high with mem_addr stable until mem_ack is sampled high.
  - At most one request is outstanding.
  - mem_ack may arrive in the same cycle as the request (zero-wait) or any later cycle.
  - mem_ack while mem_req=0 is ignored.
- Push: in FETCH, with mem_req=1 and mem_ack=1 at a clock edge:
  - {mem_data, fetch_pc} is written at the tail and count increments.
  - fetch_pc <= fetch_pc+1, wrapping modulo 2^AW (so 2^AW-1 -> 0).
- Latency: ack at edge n -> inst_vld=1 and inst=word after edge n; the core can sample it in cycle n+1.
- Pop: irie=1 and inst_vld=1 at an edge removes the head entry.
  - irie while inst_vld=0 is ignored; no underflow.
- Simultaneous push and pop: both take effect and count is unchanged.
- Full: at count=DEPTH, mem_req=0 in FETCH. A pop in cycle k allows mem_req=1 in cycle k+1.
- inst/inst_pc: combinational from the head entry. When inst_vld=0, inst=16'h0000 and inst_pc=0.
- Redirect (redir=1 at an edge) has priority over push and pop in the same cycle:
  - Buffer flushed (count=0); any irie that cycle is discarded.
  - fetch_pc <= redir_pc.
  - If mem_req=1 and mem_ack=0 that cycle: state <= DROP, drop_addr <= current mem_addr.
  - Otherwise, including a same-cycle ack whose data is discarded: state <= FETCH. The next request targets redir_pc in the following cycle.
- DROP:
  - Waits for mem_ack, discards mem_data, then goes to FETCH with the redirected fetch_pc.
  - redir during DROP updates fetch_pc only and stays in DROP; the outstanding request is never withdrawn.
- inst_vld is 0 in the cycle after a redirect, and stays 0 until the first post-redirect push.
- Reset mid-operation: all state returns to reset values immediately, and any outstanding request is abandoned.
  - The memory must itself be reset by the same rst.

Test Plan:
- Reset release, zero-wait memory (mem_ack=mem_req), mem_data=addr+16'h1000, irie=0:
  - mem_addr 0 then 1 is fetched.
  - mem_req drops with count=2, and inst=16'h1000, inst_pc=0.
- Same setup, then irie=1 each cycle:
  - Continuous stream inst=1000,1001,1002,... with inst_pc incrementing.
  - One word is popped per cycle and no word is skipped or duplicated.
- Memory latency 3 cycles, RESET_PC=8'hFE:
  - mem_req/mem_addr is held stable until ack.
  - Fetched addresses are FE, FF, 00 (wrap), and inst_pc follows.
- Redirect to 8'h40 in the same cycle as mem_ack for address 5:
  - The data for address 5 never appears.
  - The next mem_addr is 40, and the first valid inst_pc is 40.
- Redirect to 8'h80 while request 7 is pending (latency 4):
  - State is DROP and mem_addr stays 7 until ack.
  - The ack data is discarded; then mem_addr=80 and inst_pc=80.
- Async reset asserted mid-wait (between clock edges):
  - mem_req, inst_vld and count drop to 0 immediately.
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch16_if.sv
// Instruction-memory bus between ifetch16 and the instruction memory.
// A request is held (mem_req/mem_addr stable) until mem_ack is seen high;
// mem_data carries the instruction word in the cycle mem_ack is high.
//   mem_req   : fetch request (master -> slave)
//   mem_addr  : word address of the request (master -> slave)
//   mem_ack   : request completes this cycle (slave -> master)
//   mem_data  : 16-bit instruction word, valid with mem_ack (slave -> master)
interface ifetch16_if #(
    parameter int AW = 8
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [15:0]   mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data
    );
endinterface

// File: rtl/ifetch16.sv
// Instruction fetch stage feeding the 8-bit core's 16-bit inst input.
// Keeps a program counter, fetches words over a req/ack memory bus and holds
// up to DEPTH prefetched words; the oldest is presented to the core with a
// valid flag and is popped by the core's IR load enable. A redirect flushes
// the buffer and restarts fetching at a new address; a request still in
// flight at that moment is completed and its data thrown away.
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active low
//   mem       : instruction-memory bus (master side)
//   inst      : oldest buffered word, 0 when inst_vld=0
//   inst_vld  : inst holds a valid word
//   inst_pc   : address of the word on inst, 0 when inst_vld=0
//   irie      : core consumes the head word
//   redir     : redirect (taken jump/branch)
//   redir_pc  : redirect target
module ifetch16 #(
    parameter int            AW       = 8,
    parameter int            DEPTH    = 2,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    ifetch16_if.master    mem,
    output logic [15:0]   inst,
    output logic          inst_vld,
    output logic [AW-1:0] inst_pc,
    input  logic          irie,
    input  logic          redir,
    input  logic [AW-1:0] redir_pc
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] drop_addr;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          full;
    logic          push;
    logic          pop;

    logic [15:0]   fifo_data [DEPTH];
    logic [AW-1:0] fifo_pc   [DEPTH];

    assign full = (count == CW'(DEPTH));

    // Redirect wins over push and pop: data acked in a redirect cycle is
    // discarded and any pop request is ignored.
    assign push = (state == FETCH) && mem.mem_req && mem.mem_ack && !redir;
    assign pop  = irie && inst_vld && !redir;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        mem.mem_req  = 1'b0;
        mem.mem_addr = fetch_pc;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                mem.mem_req = !full;
                // A redirect cannot withdraw a pending request; park in DROP
                // until the memory answers it.
                if (redir && mem.mem_req && !mem.mem_ack) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = drop_addr;
                // Leaves on the ack even if a new redirect arrives in the same
                // cycle: the abandoned request is finished either way.
                if (mem.mem_ack) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else if (redir) begin
            fetch_pc <= redir_pc;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            if (state == FETCH && mem.mem_req && !mem.mem_ack) begin
                drop_addr <= mem.mem_addr;
            end
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + AW'(1);
                wr_ptr   <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Buffer storage is not reset; the outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem.mem_data;
            fifo_pc[wr_ptr]   <= fetch_pc;
        end
    end

    assign inst_vld = (count != '0);
    assign inst     = inst_vld ? fifo_data[rd_ptr] : 16'h0000;
    assign inst_pc  = inst_vld ? fifo_pc[rd_ptr]   : '0;
endmodule

// File: tb/tb_ifetch16.sv
module tb_ifetch16;
    logic        clk;
    logic        rst_a;
    logic        rst_b;
    logic [15:0] inst;
    logic        inst_vld;
    logic [7:0]  inst_pc;
    logic        irie;
    logic        redir;
    logic [7:0]  redir_pc;
    logic [15:0] inst_b;
    logic        inst_vld_b;
    logic [7:0]  inst_pc_b;
    logic        irie_b;
    int          lat_a;
    int          cnt_a;
    int          cnt_b;
    int          checks;
    int          errors;

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  pc;
    } ent_t;

    ent_t        exp_q [$];
    logic [7:0]  exp_fetch;
    logic        drop_pending;
    logic [7:0]  drop_exp;

    ifetch16_if #(.AW(8)) ma ();
    ifetch16_if #(.AW(8)) mb ();

    ifetch16 #(.AW(8), .DEPTH(2), .RESET_PC(8'h00)) dut_a (
        .clk      (clk),
        .rst      (rst_a),
        .mem      (ma),
        .inst     (inst),
        .inst_vld (inst_vld),
        .inst_pc  (inst_pc),
        .irie     (irie),
        .redir    (redir),
        .redir_pc (redir_pc)
    );

    ifetch16 #(.AW(8), .DEPTH(2), .RESET_PC(8'hFE)) dut_b (
        .clk      (clk),
        .rst      (rst_b),
        .mem      (mb),
        .inst     (inst_b),
        .inst_vld (inst_vld_b),
        .inst_pc  (inst_pc_b),
        .irie     (irie_b),
        .redir    (1'b0),
        .redir_pc (8'h00)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: word = 16'h1000 + address; ack after 'lat' wait cycles.
    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) cnt_a <= 0;
        else if (ma.mem_req && !ma.mem_ack) cnt_a <= cnt_a + 1;
        else cnt_a <= 0;
    end
    assign ma.mem_ack  = ma.mem_req && (cnt_a >= lat_a);
    assign ma.mem_data = {8'h10, ma.mem_addr};

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) cnt_b <= 0;
        else if (mb.mem_req && !mb.mem_ack) cnt_b <= cnt_b + 1;
        else cnt_b <= 0;
    end
    assign mb.mem_ack  = mb.mem_req && (cnt_b >= 3);
    assign mb.mem_data = {8'h10, mb.mem_addr};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for dut_a: compare head against the oldest expected word,
    // pop on a consuming cycle, push a new expectation on each accepted ack.
    task automatic sb_step();
        ent_t e;
        if (inst_vld) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("sb_inst", 32'(inst), 32'(exp_q[0].data));
                chk("sb_pc", 32'(inst_pc), 32'(exp_q[0].pc));
                if (irie && !redir) void'(exp_q.pop_front());
            end
        end else begin
            chk("empty_inst", 32'(inst), 32'h0);
            chk("empty_pc", 32'(inst_pc), 32'h0);
        end
        if (ma.mem_req && ma.mem_ack) begin
            if (drop_pending) begin
                chk("drop_addr", 32'(ma.mem_addr), 32'(drop_exp));
                drop_pending = 1'b0;
            end else begin
                chk("fetch_addr", 32'(ma.mem_addr), 32'(exp_fetch));
                if (!redir) begin
                    e.data = 16'h1000 + 16'(exp_fetch);
                    e.pc   = exp_fetch;
                    exp_q.push_back(e);
                end
                exp_fetch = exp_fetch + 8'd1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        if (rst_a) sb_step();
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_a = 1'b0; rst_b = 1'b0;
        irie = 1'b0; irie_b = 1'b0; redir = 1'b0; redir_pc = 8'h00;
        lat_a = 0; exp_fetch = 8'h00; drop_pending = 1'b0; drop_exp = 8'h00;

        // Reset state
        sample();
        chk("rst_req", 32'(ma.mem_req), 32'd0);
        chk("rst_addr", 32'(ma.mem_addr), 32'h00);
        chk("rst_vld", 32'(inst_vld), 32'd0);
        chk("rst_inst", 32'(inst), 32'h0000);
        chk("rst_pc", 32'(inst_pc), 32'h00);

        // Zero-wait fill, irie=0
        step(); rst_a = 1'b1;
        sample(); chk("idle_req", 32'(ma.mem_req), 32'd0);
        step(); sample();
        chk("fill_req0", 32'(ma.mem_req), 32'd1);
        chk("fill_addr0", 32'(ma.mem_addr), 32'h00);
        step(); sample();
        chk("fill_addr1", 32'(ma.mem_addr), 32'h01);
        step(); sample();
        chk("full_req", 32'(ma.mem_req), 32'd0);
        chk("full_inst", 32'(inst), 32'h1000);
        chk("full_pc", 32'(inst_pc), 32'h00);

        // Continuous stream, one pop per cycle
        step(); irie = 1'b1;
        for (int i = 0; i < 12; i++) begin
            sample();
            chk("stream_vld", 32'(inst_vld), 32'd1);
            chk("stream_pc", 32'(inst_pc), 32'(i));
            chk("stream_inst", 32'(inst), 32'h1000 + 32'(i));
            step();
        end
        irie = 1'b0;
        sample(); step(); sample();

        // Redirect to 40 in the same cycle as the ack for address 5
        step(); redir = 1'b1; redir_pc = 8'h05;
        sample();
        step(); redir_pc = 8'h40; exp_q.delete(); exp_fetch = 8'h05;
        sample();
        chk("r5_req", 32'(ma.mem_req), 32'd1);
        chk("r5_addr", 32'(ma.mem_addr), 32'h05);
        chk("r5_ack", 32'(ma.mem_ack), 32'd1);
        step(); redir = 1'b0; exp_q.delete(); exp_fetch = 8'h40;
        sample();
        chk("r40_vld", 32'(inst_vld), 32'd0);
        chk("r40_addr", 32'(ma.mem_addr), 32'h40);
        step(); sample();
        chk("r40_first_vld", 32'(inst_vld), 32'd1);
        chk("r40_first_pc", 32'(inst_pc), 32'h40);
        chk("r40_first_inst", 32'(inst), 32'h1040);
        step(); lat_a = 4;
        sample(); chk("r40_full_req", 32'(ma.mem_req), 32'd0);

        // Redirect to 80 while request 7 is pending (latency 4)
        step(); redir = 1'b1; redir_pc = 8'h07;
        sample();
        step(); redir = 1'b0; exp_q.delete(); exp_fetch = 8'h07;
        sample();
        chk("p7_req", 32'(ma.mem_req), 32'd1);
        chk("p7_addr", 32'(ma.mem_addr), 32'h07);
        chk("p7_ack", 32'(ma.mem_ack), 32'd0);
        step(); redir = 1'b1; redir_pc = 8'h80;
        sample();
        chk("d7_addr_redir", 32'(ma.mem_addr), 32'h07);
        step(); redir = 1'b0; drop_pending = 1'b1; drop_exp = 8'h07;
        exp_fetch = 8'h80; exp_q.delete();
        sample();
        chk("d7_req_hold", 32'(ma.mem_req), 32'd1);
        chk("d7_addr_hold", 32'(ma.mem_addr), 32'h07);
        chk("d7_vld", 32'(inst_vld), 32'd0);
        step(); sample();
        chk("d7_addr_hold2", 32'(ma.mem_addr), 32'h07);
        chk("d7_noack", 32'(ma.mem_ack), 32'd0);
        step(); sample();
        chk("d7_addr_ack", 32'(ma.mem_addr), 32'h07);
        chk("d7_ack", 32'(ma.mem_ack), 32'd1);
        step(); sample();
        chk("r80_req", 32'(ma.mem_req), 32'd1);
        chk("r80_addr", 32'(ma.mem_addr), 32'h80);
        chk("r80_vld", 32'(inst_vld), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(); sample();
            chk("r80_addr_hold", 32'(ma.mem_addr), 32'h80);
            chk("r80_vld_wait", 32'(inst_vld), 32'd0);
        end
        step(); sample();
        chk("r80_ack", 32'(ma.mem_ack), 32'd1);
        step(); sample();
        chk("r80_first_vld", 32'(inst_vld), 32'd1);
        chk("r80_first_pc", 32'(inst_pc), 32'h80);
        chk("r80_first_inst", 32'(inst), 32'h1080);

        // Asynchronous reset between clock edges, with a request outstanding
        #2 rst_a = 1'b0;
        #1;
        chk("arst_req", 32'(ma.mem_req), 32'd0);
        chk("arst_vld", 32'(inst_vld), 32'd0);
        chk("arst_inst", 32'(inst), 32'h0000);
        chk("arst_pc", 32'(inst_pc), 32'h00);
        chk("arst_addr", 32'(ma.mem_addr), 32'h00);
        exp_q.delete(); exp_fetch = 8'h00; drop_pending = 1'b0;
        lat_a = 0; irie = 1'b1;
        step(); step(); rst_a = 1'b1;
        sample();
        chk("rr_idle_req", 32'(ma.mem_req), 32'd0);
        chk("rr_idle_vld", 32'(inst_vld), 32'd0);
        step(); sample();
        chk("rr_req", 32'(ma.mem_req), 32'd1);
        chk("rr_addr", 32'(ma.mem_addr), 32'h00);
        for (int i = 0; i < 6; i++) begin
            step(); sample();
        end
        step(); irie = 1'b0;
        sample(); step(); sample();

        // Latency 3 from RESET_PC=FE, address wrap
        step(); rst_b = 1'b1;
        sample(); chk("b_idle_req", 32'(mb.mem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(); sample();
            chk("b_fe_req", 32'(mb.mem_req), 32'd1);
            chk("b_fe_addr", 32'(mb.mem_addr), 32'hFE);
            chk("b_fe_ack", 32'(mb.mem_ack), 32'(i == 3));
        end
        step(); sample();
        chk("b_fe_vld", 32'(inst_vld_b), 32'd1);
        chk("b_fe_pc", 32'(inst_pc_b), 32'hFE);
        chk("b_fe_inst", 32'(inst_b), 32'h10FE);
        chk("b_ff_addr0", 32'(mb.mem_addr), 32'hFF);
        for (int i = 0; i < 3; i++) begin
            step(); sample();
            chk("b_ff_req", 32'(mb.mem_req), 32'd1);
            chk("b_ff_addr", 32'(mb.mem_addr), 32'hFF);
            chk("b_ff_ack", 32'(mb.mem_ack), 32'(i == 2));
        end
        step(); irie_b = 1'b1;
        sample();
        chk("b_full_req", 32'(mb.mem_req), 32'd0);
        chk("b_full_pc", 32'(inst_pc_b), 32'hFE);
        step(); irie_b = 1'b0;
        sample();
        chk("b_pop_pc", 32'(inst_pc_b), 32'hFF);
        chk("b_pop_inst", 32'(inst_b), 32'h10FF);
        chk("b_wrap_req", 32'(mb.mem_req), 32'd1);
        chk("b_wrap_addr", 32'(mb.mem_addr), 32'h00);
        for (int i = 0; i < 3; i++) begin
            step(); sample();
            chk("b_wrap_addr_hold", 32'(mb.mem_addr), 32'h00);
            chk("b_wrap_ack", 32'(mb.mem_ack), 32'(i == 2));
        end
        step(); sample();
        chk("b_full2_req", 32'(mb.mem_req), 32'd0);
        step(); irie_b = 1'b1;
        sample();
        step(); irie_b = 1'b0;
        sample();
        chk("b_wrap_pc", 32'(inst_pc_b), 32'h00);
        chk("b_wrap_inst", 32'(inst_b), 32'h1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
